hyperbus_wdata_serializer: RTL and testbench



---
 rtl/hyperbus_wdata_serializer_pkg.sv | 31 +++
 rtl/hyperbus_wdata_serializer.sv | 117 +++++++++++
 tb/tb_hyperbus_wdata_serializer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_wdata_serializer_pkg.sv
`default_nettype none
// ============================================================================
// hyperbus_wdata_serializer_pkg : shared types for the HyperBus write serializer
// Revision: 1.0
// ============================================================================
package hyperbus_wdata_serializer_pkg;

  localparam int unsigned AxiDataWidthDef = 32;
  localparam int unsigned PhyDataWidthDef = 16;
  localparam int unsigned AxiStrbWidthDef = AxiDataWidthDef / 8;
  localparam int unsigned PhyStrbWidthDef = PhyDataWidthDef / 8;

  typedef struct packed {
    logic [AxiDataWidthDef-1:0] data;
    logic [AxiStrbWidthDef-1:0] strb;
    logic                       last;
  } axi_wword_t;

  typedef struct packed {
    logic [PhyDataWidthDef-1:0] data;
    logic [PhyStrbWidthDef-1:0] mask;
    logic                       last;
  } phy_beat_t;

  typedef enum logic [0:0] {
    Idle  = 1'b0,
    Shift = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hyperbus_wdata_serializer.sv
`default_nettype none
// ============================================================================
// hyperbus_wdata_serializer : splits AXI write words into PHY beats + RWDS mask
// Revision: 1.0
// ============================================================================
module hyperbus_wdata_serializer
  import hyperbus_wdata_serializer_pkg::*;
#(
  // Widths must match the package struct layout (AxiDataWidthDef/PhyDataWidthDef).
  parameter int unsigned AxiDataWidth = AxiDataWidthDef,
  parameter int unsigned PhyDataWidth = PhyDataWidthDef,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [AxiDataWidth-1:0]   data_i,
  input  logic [AxiDataWidth/8-1:0] strb_i,
  input  logic                      last_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [PhyDataWidth-1:0]   data_o,
  output logic [PhyDataWidth/8-1:0] mask_o,
  output logic                      last_o,
  output logic [CntWidth-1:0]       beat_cnt_o,
  output logic                      busy_o
);

  localparam int unsigned NumBeats = AxiDataWidth / PhyDataWidth;
  localparam int unsigned PhyStrbW = PhyDataWidth / 8;
  localparam int unsigned IdxWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBeats - 1);

  state_e              state_q;
  axi_wword_t          buf_q;
  logic [IdxWidth-1:0] beat_idx_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;

  phy_beat_t beat;
  logic      final_beat;
  logic      out_hs;

  assign final_beat = (beat_idx_q == LastIdx);
  assign valid_o    = (state_q == Shift);
  assign busy_o     = (state_q == Shift);
  assign out_hs     = valid_o & ready_i;
  // Opening the input on the final-beat handshake gives zero-bubble handover.
  assign ready_o    = (state_q == Idle) | (valid_o & final_beat & ready_i);

  always_comb begin
    beat      = '0;
    beat.data = buf_q.data[int'(beat_idx_q)*PhyDataWidth +: PhyDataWidth];
    beat.mask = ~buf_q.strb[int'(beat_idx_q)*PhyStrbW +: PhyStrbW];
    beat.last = buf_q.last & final_beat;
  end

  assign data_o = beat.data;
  assign mask_o = beat.mask;
  assign last_o = beat.last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= Idle;
      beat_idx_q <= '0;
      buf_q      <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (valid_i) begin
            buf_q      <= '{data: data_i, strb: strb_i, last: last_i};
            beat_idx_q <= '0;
            state_q    <= Shift;
          end
        end
        Shift: begin
          if (ready_i) begin
            if (!final_beat) begin
              beat_idx_q <= beat_idx_q + IdxWidth'(1);
            end else if (valid_i) begin
              buf_q      <= '{data: data_i, strb: strb_i, last: last_i};
              beat_idx_q <= '0;
            end else begin
              state_q    <= Idle;
            end
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  // Counter register holds completed beats; the displayed value adds the beat on the bus.
  always_comb begin
    cnt_d = cnt_q;
    if (out_hs) begin
      if (beat.last) begin
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt_o = (cnt_q == '1) ? cnt_q : cnt_q + CntWidth'(valid_o);

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_wdata_serializer.sv
`default_nettype none
// ============================================================================
// tb_hyperbus_wdata_serializer : scoreboard bench for the write-data serializer
// Revision: 1.0
// ============================================================================
module tb_hyperbus_wdata_serializer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic [3:0]  strb_i;
  logic        last_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] data_o;
  logic [1:0]  mask_o;
  logic        last_o;
  logic [15:0] beat_cnt_o;
  logic        busy_o;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  mask;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  hyperbus_wdata_serializer #(
    .AxiDataWidth(32),
    .PhyDataWidth(16),
    .CntWidth    (16)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .strb_i    (strb_i),
    .last_i    (last_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .mask_o    (mask_o),
    .last_o    (last_o),
    .beat_cnt_o(beat_cnt_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: low half first, mask is inverted strobe, last only on the high half.
  task automatic push_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    exp_q.push_back('{data: d[15:0],  mask: ~s[1:0], last: 1'b0});
    exp_q.push_back('{data: d[31:16], mask: ~s[3:2], last: l});
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    data_i = '0; strb_i = '0; last_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o: got %b expected 0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_o: got %b expected 1", ready_o); end
    n_checks++; if (data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data_o: got %h expected 0000", data_o); end
    n_checks++; if (mask_o !== 2'b11) begin n_fail++; $display("FAIL reset_mask_o: got %b expected 11", mask_o); end
    n_checks++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last_o: got %b expected 0", last_o); end
    n_checks++; if (beat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_o: got %b expected 0", busy_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_single_last();
    exp_t e;
    @(posedge clk_i); #1;
    ready_i = 1'b1; valid_i = 1'b1; data_i = 32'hDDCC_BBAA; strb_i = 4'b1111; last_i = 1'b1;
    @(negedge clk_i);
    if (valid_i && ready_o) push_word(data_i, strb_i, last_i);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid beat%0d: got %b expected 1", b, valid_o); end
      n_checks++; if (beat_cnt_o !== 16'(b + 1)) begin n_fail++; $display("FAIL single_cnt beat%0d: got %0d expected %0d", b, beat_cnt_o, b + 1); end
      n_checks++; if (ready_o !== 1'(b)) begin n_fail++; $display("FAIL single_ready_o beat%0d: got %b expected %0d", b, ready_o, b); end
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_beat: got unexpected beat %h expected none", data_o); end
      else begin
        e = exp_q.pop_front();
        if ({data_o, mask_o, last_o} !== e) begin n_fail++; $display("FAIL single_beat%0d: got %h/%b/%b expected %h/%b/%b", b, data_o, mask_o, last_o, e.data, e.mask, e.last); end
      end
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %b expected 0", valid_o); end
    n_checks++; if (beat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL single_cnt_clear: got %0d expected 0", beat_cnt_o); end
  endtask

  task automatic test_strb_mask();
    exp_t e;
    @(posedge clk_i); #1;
    ready_i = 1'b1; valid_i = 1'b1; data_i = 32'h4433_2211; strb_i = 4'b0110; last_i = 1'b1;
    @(negedge clk_i);
    if (valid_i && ready_o) push_word(data_i, strb_i, last_i);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk_i);
      n_checks++;
      if (!valid_o || exp_q.size() == 0) begin n_fail++; $display("FAIL strb_beat%0d: got valid=%b queued=%0d expected valid beat", b, valid_o, exp_q.size()); end
      else begin
        e = exp_q.pop_front();
        if ({data_o, mask_o, last_o} !== e) begin n_fail++; $display("FAIL strb_beat%0d: got %h/%b/%b expected %h/%b/%b", b, data_o, mask_o, last_o, e.data, e.mask, e.last); end
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_all_masked();
    exp_t e;
    @(posedge clk_i); #1;
    ready_i = 1'b1; valid_i = 1'b1; data_i = 32'h1234_5678; strb_i = 4'b0000; last_i = 1'b1;
    @(negedge clk_i);
    if (valid_i && ready_o) push_word(data_i, strb_i, last_i);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk_i);
      n_checks++;
      if (!valid_o || exp_q.size() == 0) begin n_fail++; $display("FAIL masked_beat%0d: got valid=%b queued=%0d expected valid beat", b, valid_o, exp_q.size()); end
      else begin
        e = exp_q.pop_front();
        if ({data_o, mask_o, last_o} !== e) begin n_fail++; $display("FAIL masked_beat%0d: got %h/%b/%b expected %h/%b/%b", b, data_o, mask_o, last_o, e.data, e.mask, e.last); end
      end
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL masked_idle: got valid=%b expected 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [3] = '{32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908};
    logic [3:0]  ws [3] = '{4'b1111, 4'b1111, 4'b1001};
    logic        wl [3] = '{1'b0, 1'b0, 1'b1};
    int   wi = 0, k = 0, gaps = 0;
    bit   started = 1'b0, acc;
    exp_t e;
    @(posedge clk_i); #1;
    ready_i = 1'b1; valid_i = 1'b1; data_i = wd[0]; strb_i = ws[0]; last_i = wl[0];
    for (int cyc = 0; cyc < 12 && k < 6; cyc++) begin
      @(negedge clk_i);
      if (valid_o) begin
        started = 1'b1;
        n_checks++; if (ready_o !== 1'(k % 2)) begin n_fail++; $display("FAIL b2b_ready_o beat%0d: got %b expected %0d", k + 1, ready_o, k % 2); end
        n_checks++; if (beat_cnt_o !== 16'(k + 1)) begin n_fail++; $display("FAIL b2b_cnt beat%0d: got %0d expected %0d", k + 1, beat_cnt_o, k + 1); end
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_beat%0d: got unexpected %h expected none", k + 1, data_o); end
        else begin
          e = exp_q.pop_front();
          if ({data_o, mask_o, last_o} !== e) begin n_fail++; $display("FAIL b2b_beat%0d: got %h/%b/%b expected %h/%b/%b", k + 1, data_o, mask_o, last_o, e.data, e.mask, e.last); end
        end
        k++;
      end else if (started) begin
        gaps++;
      end
      acc = valid_i && ready_o;
      if (acc) begin push_word(data_i, strb_i, last_i); wi++; end
      @(posedge clk_i); #1;
      if (acc) begin
        if (wi < 3) begin data_i = wd[wi]; strb_i = ws[wi]; last_i = wl[wi]; end
        else valid_i = 1'b0;
      end
    end
    n_checks++; if (k !== 6 || gaps !== 0) begin n_fail++; $display("FAIL b2b_stream: got beats=%0d gaps=%0d expected beats=6 gaps=0", k, gaps); end
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got valid=%b expected 0", valid_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] wd [2] = '{32'h8765_4321, 32'h0FED_CBA9};
    logic [3:0]  ws [2] = '{4'b1111, 4'b1100};
    logic        wl [2] = '{1'b0, 1'b1};
    int   wi = 0, k = 0, stall = 0;
    bit   acc;
    exp_t e;
    @(posedge clk_i); #1;
    ready_i = 1'b1; valid_i = 1'b1; data_i = wd[0]; strb_i = ws[0]; last_i = wl[0];
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      @(negedge clk_i);
      if (!ready_i) begin
        n_checks++;
        if (valid_o !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL bp_hold_valid: got valid=%b expected 1", valid_o); end
        else if ({data_o, mask_o, last_o} !== exp_q[0]) begin n_fail++; $display("FAIL bp_hold_stable: got %h/%b/%b expected %h/%b/%b", data_o, mask_o, last_o, exp_q[0].data, exp_q[0].mask, exp_q[0].last); end
        n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_o: got %b expected 0", ready_o); end
      end
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_beat: got unexpected %h expected none", data_o); end
        else begin
          e = exp_q.pop_front();
          if ({data_o, mask_o, last_o} !== e) begin n_fail++; $display("FAIL bp_beat%0d: got %h/%b/%b expected %h/%b/%b", k, data_o, mask_o, last_o, e.data, e.mask, e.last); end
        end
        k++;
      end
      acc = valid_i && ready_o;
      if (acc) begin push_word(data_i, strb_i, last_i); wi++; end
      @(posedge clk_i); #1;
      if (acc) begin
        if (wi < 2) begin data_i = wd[wi]; strb_i = ws[wi]; last_i = wl[wi]; end
        else valid_i = 1'b0;
      end
      if (k == 1 && stall < 3) begin ready_i = 1'b0; stall++; end
      else ready_i = 1'b1;
    end
    n_checks++; if (k !== 4 || exp_q.size() != 0 || stall !== 3) begin n_fail++; $display("FAIL bp_complete: got beats=%0d left=%0d stalls=%0d expected 4/0/3", k, exp_q.size(), stall); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(posedge clk_i); #1;
    ready_i = 1'b1; valid_i = 1'b1; data_i = 32'hCAFE_BABE; strb_i = 4'b1111; last_i = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat0_present: got valid=%b expected 1", valid_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", valid_o); end
    n_checks++; if (beat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", beat_cnt_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_o: got %b expected 1", ready_o); end
    exp_q.delete();
    @(posedge clk_i); #1;
    valid_i = 1'b1; data_i = 32'h5A5A_A5A5; strb_i = 4'b1111; last_i = 1'b1;
    @(negedge clk_i);
    if (valid_i && ready_o) push_word(data_i, strb_i, last_i);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk_i);
      n_checks++;
      if (!valid_o || exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_fresh%0d: got valid=%b queued=%0d expected valid beat", b, valid_o, exp_q.size()); end
      else begin
        e = exp_q.pop_front();
        if ({data_o, mask_o, last_o} !== e) begin n_fail++; $display("FAIL rstmid_fresh%0d: got %h/%b/%b expected %h/%b/%b", b, data_o, mask_o, last_o, e.data, e.mask, e.last); end
      end
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_end_idle: got valid=%b expected 0", valid_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_last();
    test_strb_mask();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_all_masked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
